// File: rtl/note_highway_if.sv
// note_highway_if: control, strum and display signals of the note-lane engine
// master: game logic side (drives iEnable, spawn_valid/spawn_lane, guitar_in)
// slave : note_highway (drives spawn_ready, note_x/note_vld, pulses, score, streak, miss_cnt, state)
interface note_highway_if #(
    parameter int NUM_LANES = 3,
    parameter int DEPTH     = 4,
    parameter int X_W       = 11,
    parameter int SCORE_W   = 16
);
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    logic                           iEnable;
    logic                           spawn_valid;
    logic [LW-1:0]                  spawn_lane;
    logic                           spawn_ready;
    logic [NUM_LANES-1:0]           guitar_in;
    logic [NUM_LANES*DEPTH*X_W-1:0] note_x;
    logic [NUM_LANES*DEPTH-1:0]     note_vld;
    logic [NUM_LANES-1:0]           hit_pulse;
    logic [NUM_LANES-1:0]           miss_pulse;
    logic [SCORE_W-1:0]             score;
    logic [7:0]                     streak;
    logic [7:0]                     miss_cnt;
    logic [1:0]                     state;
    modport master (
        output iEnable, spawn_valid, spawn_lane, guitar_in,
        input  spawn_ready, note_x, note_vld, hit_pulse, miss_pulse, score, streak, miss_cnt, state
    );
    modport slave (
        input  iEnable, spawn_valid, spawn_lane, guitar_in,
        output spawn_ready, note_x, note_vld, hit_pulse, miss_pulse, score, streak, miss_cnt, state
    );
endinterface

// File: rtl/note_highway.sv
// note_highway: NUM_LANES lanes of DEPTH-slot note FIFOs scrolling toward the hit line; scores strums, counts misses
// Ports: slowclock (game tick), iRST_n (async, active-low), bus (note_highway_if.slave):
//   iEnable run/pause, spawn_valid/spawn_lane/spawn_ready spawn handshake, guitar_in strum buttons,
//   note_x/note_vld slot display, hit_pulse/miss_pulse, score, streak, miss_cnt, state (0 IDLE,1 RUN,2 PAUSE,3 OVER)
// Build option: NOTE_HIGHWAY_DEBOUNCE_EN debounces guitar_in (two equal samples) before edge detection.
module note_highway #(
    parameter int NUM_LANES    = 3,
    parameter int DEPTH        = 4,
    parameter int X_W          = 11,
    parameter int SPAWN_X      = 310,
    parameter int HIT_X        = 50,
    parameter int HIT_WIN      = 12,
    parameter int SPEED        = 4,
    parameter int SCORE_W      = 16,
    parameter int STREAK_BONUS = 8,
    parameter int MISS_LIMIT   = 0
) (
    input logic           slowclock,
    input logic           iRST_n,
    note_highway_if.slave bus
);
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [X_W-1:0] X_SPAWN  = X_W'(SPAWN_X);
    localparam logic [X_W-1:0] X_LO     = X_W'(HIT_X - HIT_WIN);
    localparam logic [X_W-1:0] X_HI     = X_W'(HIT_X + HIT_WIN);
    localparam logic [X_W-1:0] X_EXP    = X_W'(HIT_X - HIT_WIN + SPEED);
    localparam logic [X_W-1:0] X_STEP   = X_W'(SPEED);
    localparam logic [7:0]     STREAK_B = 8'(STREAK_BONUS);
    localparam logic [7:0]     MISS_LIM = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_t;
    state_t r_state, w_state_nxt;

    logic [X_W-1:0]       r_x [NUM_LANES][DEPTH];
    logic [DEPTH-1:0]     r_vld [NUM_LANES];
    logic [PW-1:0]        r_head [NUM_LANES];
    logic [PW-1:0]        r_tail [NUM_LANES];
    logic [NUM_LANES-1:0] r_prev, r_hit, r_miss;
    logic [NUM_LANES-1:0] w_lvl, w_edge, w_hit, w_miss, w_ghost, w_spawn;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic [SCORE_W+1:0]   w_score_sum;
    logic [7:0]           r_streak, r_miss_cnt, w_streak_nxt, w_miss_nxt;
    logic [8:0]           w_streak_sum, w_miss_sum;
    logic [(1<<LW)-1:0]   w_full;
    logic                 w_run, w_bonus;
    logic [NUM_LANES*DEPTH*X_W-1:0] w_note_x;
    logic [NUM_LANES*DEPTH-1:0]     w_note_vld;

`ifdef NOTE_HIGHWAY_DEBOUNCE_EN
    logic [NUM_LANES-1:0] r_smp, r_deb;
    // level follows the input only once two consecutive samples agree
    always_ff @(posedge slowclock or negedge iRST_n) begin
        if (!iRST_n) begin
            r_smp <= '0;
            r_deb <= '0;
        end else begin
            r_smp <= bus.guitar_in;
            r_deb <= (~(bus.guitar_in ^ r_smp) & bus.guitar_in) | ((bus.guitar_in ^ r_smp) & r_deb);
        end
    end
    assign w_lvl = r_deb;
`else
    assign w_lvl = bus.guitar_in;
`endif

    assign w_run   = r_state == S_RUN;
    assign w_bonus = r_streak >= STREAK_B;
    assign w_edge  = w_lvl & ~r_prev;

    // a FIFO is full when its tail slot is still occupied; lanes past NUM_LANES read as full
    always_comb begin
        w_full = '1;
        for (int k = 0; k < NUM_LANES; k++) w_full[k] = r_vld[k][r_tail[k]];
    end

    assign bus.spawn_ready = w_run && !w_full[bus.spawn_lane];

    // only the head can hit or expire since every note moves at the same speed
    always_comb begin
        w_hit        = '0;
        w_miss       = '0;
        w_ghost      = '0;
        w_spawn      = '0;
        w_score_sum  = {2'b00, r_score};
        w_streak_sum = {1'b0, r_streak};
        w_miss_sum   = {1'b0, r_miss_cnt};
        for (int k = 0; k < NUM_LANES; k++) begin
            w_hit[k]     = w_run && w_edge[k] && r_vld[k][r_head[k]] &&
                           r_x[k][r_head[k]] >= X_LO && r_x[k][r_head[k]] <= X_HI;
            w_miss[k]    = w_run && !w_hit[k] && r_vld[k][r_head[k]] && r_x[k][r_head[k]] < X_EXP;
            w_ghost[k]   = w_run && w_edge[k] && !w_hit[k];
            w_spawn[k]   = bus.spawn_valid && bus.spawn_ready && bus.spawn_lane == LW'(k);
            w_score_sum  = w_score_sum + (SCORE_W+2)'(w_hit[k] ? (w_bonus ? 2 : 1) : 0);
            w_streak_sum = w_streak_sum + 9'(w_hit[k]);
            w_miss_sum   = w_miss_sum + 9'(w_miss[k]);
        end
        w_score_nxt  = |w_score_sum[SCORE_W+1:SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        w_streak_nxt = |(w_ghost | w_miss) ? 8'd0 : (w_streak_sum[8] ? 8'hFF : w_streak_sum[7:0]);
        w_miss_nxt   = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
    end

    // the miss limit is judged on the count this tick produces, so OVER lands on the limiting expiry
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_RUN)
            w_state_nxt = (MISS_LIM != 8'd0 && w_miss_nxt >= MISS_LIM) ? S_OVER : (bus.iEnable ? S_RUN : S_PAUSE);
        else if (r_state != S_OVER && bus.iEnable)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge slowclock or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_hit      <= '0;
            r_miss     <= '0;
            r_score    <= '0;
            r_streak   <= '0;
            r_miss_cnt <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_vld[k]  <= '0;
                r_head[k] <= '0;
                r_tail[k] <= '0;
                for (int s = 0; s < DEPTH; s++) r_x[k][s] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_lvl;
            r_hit      <= w_hit;
            r_miss     <= w_miss;
            r_score    <= w_score_nxt;
            r_streak   <= w_streak_nxt;
            r_miss_cnt <= w_miss_nxt;
            // move, then pop (clears the head slot), then spawn into the empty tail slot
            for (int k = 0; k < NUM_LANES; k++) begin
                for (int s = 0; s < DEPTH; s++)
                    if (w_run && r_vld[k][s]) r_x[k][s] <= r_x[k][s] - X_STEP;
                if (w_hit[k] || w_miss[k]) begin
                    r_x[k][r_head[k]]   <= '0;
                    r_vld[k][r_head[k]] <= 1'b0;
                    r_head[k]           <= r_head[k] + PW'(1);
                end
                if (w_spawn[k]) begin
                    r_x[k][r_tail[k]]   <= X_SPAWN;
                    r_vld[k][r_tail[k]] <= 1'b1;
                    r_tail[k]           <= r_tail[k] + PW'(1);
                end
            end
        end
    end

    always_comb begin
        w_note_x   = '0;
        w_note_vld = '0;
        for (int k = 0; k < NUM_LANES; k++)
            for (int s = 0; s < DEPTH; s++) begin
                w_note_x[(k*DEPTH+s)*X_W +: X_W] = r_x[k][s];
                w_note_vld[k*DEPTH+s]            = r_vld[k][s];
            end
    end

    assign bus.note_x     = w_note_x;
    assign bus.note_vld   = w_note_vld;
    assign bus.hit_pulse  = r_hit;
    assign bus.miss_pulse = r_miss;
    assign bus.score      = r_score;
    assign bus.streak     = r_streak;
    assign bus.miss_cnt   = r_miss_cnt;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_note_highway.sv
// tb_note_highway: directed checks of note_highway (default instance plus one with MISS_LIMIT=3)
module tb_note_highway;
    localparam int NL = 3, DP = 4, XW = 11, SW = 16;
`ifdef NOTE_HIGHWAY_DEBOUNCE_EN
    localparam int DL = 2;
`else
    localparam int DL = 0;
`endif
    logic slowclock = 1'b0;
    logic iRST_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    note_highway_if #(.NUM_LANES(NL), .DEPTH(DP), .X_W(XW), .SCORE_W(SW)) ha ();
    note_highway_if #(.NUM_LANES(NL), .DEPTH(DP), .X_W(XW), .SCORE_W(SW)) hb ();

    note_highway #(.NUM_LANES(NL), .DEPTH(DP), .X_W(XW), .SCORE_W(SW)) u_dut (
        .slowclock(slowclock), .iRST_n(iRST_n), .bus(ha)
    );
    note_highway #(.NUM_LANES(NL), .DEPTH(DP), .X_W(XW), .SCORE_W(SW), .MISS_LIMIT(3)) u_dut3 (
        .slowclock(slowclock), .iRST_n(iRST_n), .bus(hb)
    );

    always #5 slowclock = ~slowclock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge slowclock);
        #1;
    endtask

    // hold the strum long enough to pass the debouncer; the hit lands on the last edge
    task automatic strum(input logic [NL-1:0] m);
        ha.guitar_in = m;
        tick(1 + DL);
        ha.guitar_in = '0;
    endtask

    function automatic logic [XW-1:0] xa(input int l, input int s);
        return ha.note_x[(l*DP+s)*XW +: XW];
    endfunction

    function automatic logic [DP-1:0] va(input int l);
        return ha.note_vld[l*DP +: DP];
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ha.iEnable = 0; ha.spawn_valid = 0; ha.spawn_lane = '0; ha.guitar_in = '0;
        hb.iEnable = 0; hb.spawn_valid = 0; hb.spawn_lane = '0; hb.guitar_in = '0;
        #12;
        check("rst_state", 32'(ha.state), 0);
        check("rst_vld", 32'(ha.note_vld), 0);
        check("rst_score", 32'(ha.score), 0);
        check("rst_ready", 32'(ha.spawn_ready), 0);
        iRST_n = 1;
        ha.iEnable = 1;
        tick(1);
        check("run", 32'(ha.state), 1);

        // hit at x=62, the top of the window
        ha.spawn_valid = 1; ha.spawn_lane = 2'd0;
        #1;
        check("t1_ready", 32'(ha.spawn_ready), 1);
        tick(1);
        ha.spawn_valid = 0;
        check("t1_spawn_x", 32'(xa(0, 0)), 310);
        check("t1_spawn_vld", 32'(va(0)), 1);
        tick(62 - DL);
        check("t1_x62", 32'(xa(0, 0)), 62 + 4*DL);
        strum(3'b001);
        check("t1_hit", 32'(ha.hit_pulse), 1);
        check("t1_score", 32'(ha.score), 1);
        check("t1_streak", 32'(ha.streak), 1);
        check("t1_vld", 32'(va(0)), 0);
        tick(1);
        check("t1_pulse_clr", 32'(ha.hit_pulse), 0);

        // unstrummed note expires after passing x=38
        ha.spawn_valid = 1; ha.spawn_lane = 2'd0;
        tick(1);
        ha.spawn_valid = 0;
        tick(68);
        check("t2_x38", 32'(xa(0, 1)), 38);
        check("t2_nomiss", 32'(ha.miss_pulse), 0);
        tick(1);
        check("t2_miss", 32'(ha.miss_pulse), 1);
        check("t2_streak", 32'(ha.streak), 0);
        check("t2_misscnt", 32'(ha.miss_cnt), 1);
        check("t2_vld", 32'(va(0)), 0);

        // build streak 5 with a 3-lane and a 2-lane chord
        for (int i = 0; i < 5; i++) begin
            ha.spawn_valid = 1; ha.spawn_lane = 2'(i % 3);
            tick(1);
        end
        ha.spawn_valid = 0;
        tick(61 - DL);
        strum(3'b111);
        check("t3_chord3", 32'(ha.hit_pulse), 7);
        check("t3_score3", 32'(ha.score), 4);
        check("t3_streak3", 32'(ha.streak), 3);
        tick(1 + DL);
        strum(3'b011);
        check("t3_chord2", 32'(ha.hit_pulse), 3);
        check("t3_score5", 32'(ha.score), 6);
        check("t3_streak5", 32'(ha.streak), 5);
        check("t3_empty", 32'(ha.note_vld), 0);

        // ghost strum at x=70 clears the streak, note keeps moving
        ha.spawn_valid = 1; ha.spawn_lane = 2'd0;
        tick(1);
        ha.spawn_valid = 0;
        tick(60 - DL);
        check("t3_x70", 32'(xa(0, 0)), 70 + 4*DL);
        strum(3'b001);
        check("t3_ghost_streak", 32'(ha.streak), 0);
        check("t3_ghost_hit", 32'(ha.hit_pulse), 0);
        check("t3_ghost_miss", 32'(ha.miss_pulse), 0);
        check("t3_ghost_vld", 32'(va(0)), 1);
        check("t3_ghost_x", 32'(xa(0, 0)), 66);
        check("t3_ghost_score", 32'(ha.score), 6);

        // fill lane 1; the held 5th request waits for the first pop
        for (int i = 0; i < 4; i++) begin
            ha.spawn_valid = 1; ha.spawn_lane = 2'd1;
            #1;
            check("t4_ready_free", 32'(ha.spawn_ready), 1);
            tick(1);
        end
        check("t4_full_vld", 32'(va(1)), 15);
        check("t4_ready_full", 32'(ha.spawn_ready), 0);
        tick(59 - DL);
        check("t4_still_full", 32'(va(1)), 15);
        strum(3'b010);
        check("t4_pop_hit", 32'(ha.hit_pulse), 2);
        check("t4_score", 32'(ha.score), 7);
        check("t4_streak", 32'(ha.streak), 1);
        check("t4_misscnt", 32'(ha.miss_cnt), 2);
        check("t4_pop_vld", 32'(va(1)), 11);
        check("t4_ready_again", 32'(ha.spawn_ready), 1);
        tick(1);
        ha.spawn_valid = 0;
        check("t4_fifth_vld", 32'(va(1)), 15);
        check("t4_fifth_x", 32'(xa(1, 2)), 310);

        // pause freezes motion and ignores strums
        ha.iEnable = 0;
        tick(1);
        check("t5_pause", 32'(ha.state), 2);
        check("t5_x_enter", 32'(xa(1, 3)), 54);
        strum(3'b010);
        check("t5_nohit", 32'(ha.hit_pulse), 0);
        check("t5_streak", 32'(ha.streak), 1);
        tick(8 - DL);
        check("t5_pause_hold", 32'(ha.state), 2);
        check("t5_x_frozen", 32'(xa(1, 3)), 54);
        check("t5_score", 32'(ha.score), 7);
        ha.iEnable = 1;
        tick(1);
        check("t5_resume", 32'(ha.state), 1);
        check("t5_x_resume", 32'(xa(1, 3)), 54);
        tick(1);
        check("t5_x_moving", 32'(xa(1, 3)), 50);

        // asynchronous reset with live notes
        #2;
        iRST_n = 0;
        #1;
        check("t6_state", 32'(ha.state), 0);
        check("t6_vld", 32'(ha.note_vld), 0);
        check("t6_x", 32'(|ha.note_x), 0);
        check("t6_score", 32'(ha.score), 0);
        check("t6_streak", 32'(ha.streak), 0);
        check("t6_misscnt", 32'(ha.miss_cnt), 0);
        check("t6_ready", 32'(ha.spawn_ready), 0);
        #2;
        iRST_n = 1;

`ifdef NOTE_HIGHWAY_DEBOUNCE_EN
        // single-tick glitch inside the hit window must not register
        ha.iEnable = 1;
        tick(1);
        ha.spawn_valid = 1; ha.spawn_lane = 2'd0;
        tick(1);
        ha.spawn_valid = 0;
        tick(62);
        ha.guitar_in = 3'b001;
        tick(1);
        ha.guitar_in = '0;
        tick(4);
        check("db_glitch_score", 32'(ha.score), 0);
        check("db_glitch_vld", 32'(va(0)), 1);
`endif

        // miss limit 3 drives OVER, which is sticky
        hb.iEnable = 1;
        tick(1);
        check("ml_run", 32'(hb.state), 1);
        for (int i = 0; i < 3; i++) begin
            hb.spawn_valid = 1; hb.spawn_lane = 2'(i);
            tick(1);
        end
        hb.spawn_valid = 0;
        tick(67);
        check("ml_miss1", 32'(hb.miss_pulse), 1);
        check("ml_cnt1", 32'(hb.miss_cnt), 1);
        tick(1);
        check("ml_cnt2", 32'(hb.miss_cnt), 2);
        check("ml_state2", 32'(hb.state), 1);
        tick(1);
        check("ml_miss3", 32'(hb.miss_pulse), 4);
        check("ml_cnt3", 32'(hb.miss_cnt), 3);
        check("ml_over", 32'(hb.state), 3);
        hb.spawn_valid = 1; hb.spawn_lane = 2'd0;
        #1;
        check("ml_ready", 32'(hb.spawn_ready), 0);
        tick(1);
        check("ml_pulse_clr", 32'(hb.miss_pulse), 0);
        hb.iEnable = 0;
        tick(1);
        check("ml_sticky0", 32'(hb.state), 3);
        hb.iEnable = 1;
        tick(1);
        check("ml_sticky1", 32'(hb.state), 3);
        check("ml_novld", 32'(hb.note_vld), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
